obi_master_pipelined: RTL and testbench
=======================================

Name: obi_master_pipelined

Overview:
- Parametrised successor to the single-transaction OBI controller: bridges the core's valid/ready request interface to an OBI master port and supports up to MAX_OUTSTANDING in-flight transactions.
- Responses return in order, without per-transaction bubbles.
- Optional registered request stage gives OBI-compliant stable request signals and cuts core-to-bus timing paths.
- Sits between the LSU/fetch unit and the bus interconnect, replacing the one-at-a-time IDLE/REQUESTING/WAITING/DUMPING flow.

Parameters:
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, data width; must be 32 or 64
MAX_OUTSTANDING, 2, max accepted-but-unanswered transactions; 1..8
REG_REQ, 1, 1 = request held in register stage; 0 = combinational passthrough

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
core_valid_i  in  1  core request valid
core_ready_o  out  1  request accepted when valid&&ready
core_addr_i  in  ADDR_WIDTH  byte address
core_we_i  in  1  write enable
core_be_i  in  DATA_WIDTH/8  byte enables
core_wdata_i  in  DATA_WIDTH  write data
resp_valid_o  out  1  response valid; consumer always ready
resp_rdata_o  out  DATA_WIDTH  read data
resp_err_o  out  1  bus error for this response
obi_req_o  out  1  OBI request
obi_gnt_i  in  1  OBI grant
obi_addr_o  out  ADDR_WIDTH  word-aligned address
obi_we_o  out  1  write enable
obi_be_o  out  DATA_WIDTH/8  byte enables
obi_wdata_o  out  DATA_WIDTH  write data
obi_atop_o  out  6  atomic op; tied 6'b0
obi_rdata_i  in  DATA_WIDTH  read data
obi_rvalid_i  in  1  response valid
obi_err_i  in  1  response error
outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  in-flight count
proto_err_o  out  1  sticky: rvalid received with zero outstanding

Behaviour:
- Reset (rst=1 at posedge): request register empty, counter 0, proto_err_o=0, resp_*=0, obi_req_o=0, obi_addr/we/be/wdata=0. Reset mid-transaction abandons in-flight transactions; later rvalids count as protocol errors.
- Address alignment: obi_addr_o = core address with low $clog2(DATA_WIDTH/8) bits cleared. be and wdata pass unchanged.
- Counter:
  - +1 on issue (obi_req_o && obi_gnt_i).
  - -1 on obi_rvalid_i.
  - Both in the same cycle: unchanged.
  - Never exceeds MAX_OUTSTANDING.
  - Never underflows: rvalid at count 0 leaves count at 0 and sets proto_err_o until reset.
- Credit: can_issue = (count < MAX_OUTSTANDING) || obi_rvalid_i (a freeing response in the same cycle counts).
- REG_REQ=0:
  - obi_req_o = core_valid_i && can_issue; obi fields driven combinationally from core inputs.
  - core_ready_o = obi_gnt_i && can_issue.
- REG_REQ=1, FSM states EMPTY and FULL:
  - EMPTY: core_ready_o=1; obi_req_o=0. core_valid_i captures the request into the register -> FULL.
  - FULL: obi_req_o = can_issue. Register fields are stable while obi_req_o is waiting for gnt. obi_req_o may only deassert when can_issue is low, and has not yet risen.
  - On issue (req&&gnt): if core_valid_i, load the new request and stay FULL (back-to-back, 1 req/cycle); otherwise -> EMPTY.
  - core_ready_o = EMPTY || issue.
  - Latency: core accept to earliest obi_req_o = 1 cycle.
- Response path: resp_valid_o, resp_rdata_o, resp_err_o register obi_rvalid_i, obi_rdata_i, obi_err_i (1-cycle latency). resp_rdata_o is held when not valid. Errored transactions still decrement the counter.
- Writes also receive an rvalid response (OBI); resp_rdata_o content is don't-care for writes.

Decomposition:
- Shared package obi_pkg: obi_req_t struct (addr, we, be, wdata), OBI_ATOP_NONE constant, req_state_t enum {EMPTY, FULL}, function for the byte-offset width.
- Natural sub-module obi_req_slice: the REG_REQ register stage with its valid/ready handshake, instantiated under generate when REG_REQ=1.

Test Plan:
- Single read, gnt immediate, rvalid 2 cycles later, rdata=32'hDEADBEEF -> resp_valid_o one cycle after rvalid, rdata=DEADBEEF, err=0; outstanding_o goes 0->1->0.
- MAX_OUTSTANDING=2, gnt held high, 4 back-to-back reads, rvalid delayed -> 2 issued, third obi_req_o withheld until first rvalid; issue on same cycle as rvalid; outstanding_o never exceeds 2.
- REG_REQ=1, gnt low 3 cycles with core_addr_i changing -> obi_addr_o/be/wdata constant, obi_req_o held, core_ready_o=0 until gnt.
- Write addr=32'h1003, be=4'b1000, obi_err_i=1 on response -> obi_addr_o=32'h1000, resp_err_o=1, counter returns to 0.
- rvalid with outstanding_o=0 -> proto_err_o=1 and stays 1; outstanding_o stays 0; cleared only by rst.
- rst asserted with 2 outstanding -> next cycle all outputs at reset values; stray rvalid afterwards sets proto_err_o.

Source files
------------

// File: rtl/obi_pkg.sv
// ============================================================================
//  Module      : obi_pkg
//  Description : Shared types and helpers for the pipelined OBI master.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package obi_pkg;

    // Default request layout (32-bit address / 32-bit data); wider
    // configurations supply their own layout to the request slice.
    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } obi_req_t;

    localparam logic [5:0] OBI_ATOP_NONE = 6'b00_0000;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } req_state_t;

    // Number of address bits that select a byte within one data word.
    function automatic int unsigned obi_byte_off_bits(input int unsigned data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

`default_nettype wire

// File: rtl/obi_req_slice.sv
// ============================================================================
//  Module      : obi_req_slice
//  Description : One-entry request register holding OBI fields stable until granted.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module obi_req_slice
    import obi_pkg::*;
#(
    parameter type req_t = obi_req_t
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    output logic in_ready,
    input  req_t in_req,
    input  logic can_issue,
    input  logic gnt,
    output logic out_req,
    output req_t out_data
);

    req_state_t r_state;
    req_state_t w_state_next;
    req_t       r_req;
    logic       w_load;
    logic       w_issue;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= EMPTY;
            r_req   <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_load) begin
                r_req <= in_req;
            end
        end
    end

    // A granted entry can be replaced in the same cycle, giving one request per cycle.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_issue      = 1'b0;
        out_req      = 1'b0;
        in_ready     = 1'b0;
        case (r_state)
            EMPTY: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_load       = 1'b1;
                    w_state_next = FULL;
                end
            end
            FULL: begin
                out_req  = can_issue;
                w_issue  = can_issue && gnt;
                in_ready = w_issue;
                if (w_issue) begin
                    if (in_valid) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_next = EMPTY;
                    end
                end
            end
            default: begin
                w_state_next = EMPTY;
            end
        endcase
    end

    assign out_data = r_req;

endmodule

`default_nettype wire

// File: rtl/obi_master_pipelined.sv
// ============================================================================
//  Module      : obi_master_pipelined
//  Description : Core valid/ready to OBI master bridge with multiple in-flight transactions.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module obi_master_pipelined
    import obi_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2,
    parameter int REG_REQ         = 1
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     core_valid_i,
    output logic                                     core_ready_o,
    input  logic [ADDR_WIDTH-1:0]                    core_addr_i,
    input  logic                                     core_we_i,
    input  logic [DATA_WIDTH/8-1:0]                  core_be_i,
    input  logic [DATA_WIDTH-1:0]                    core_wdata_i,
    output logic                                     resp_valid_o,
    output logic [DATA_WIDTH-1:0]                    resp_rdata_o,
    output logic                                     resp_err_o,
    output logic                                     obi_req_o,
    input  logic                                     obi_gnt_i,
    output logic [ADDR_WIDTH-1:0]                    obi_addr_o,
    output logic                                     obi_we_o,
    output logic [DATA_WIDTH/8-1:0]                  obi_be_o,
    output logic [DATA_WIDTH-1:0]                    obi_wdata_o,
    output logic [5:0]                               obi_atop_o,
    input  logic [DATA_WIDTH-1:0]                    obi_rdata_i,
    input  logic                                     obi_rvalid_i,
    input  logic                                     obi_err_i,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]     outstanding_o,
    output logic                                     proto_err_o
);

    localparam int unsigned              c_OFF_BITS = obi_byte_off_bits(DATA_WIDTH);
    localparam int                       c_CNT_W    = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [c_CNT_W-1:0]       c_MAX      = c_CNT_W'(MAX_OUTSTANDING);
    localparam logic [ADDR_WIDTH-1:0]    c_OFF_MASK = ADDR_WIDTH'((64'd1 << c_OFF_BITS) - 64'd1);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]   addr;
        logic                    we;
        logic [DATA_WIDTH/8-1:0] be;
        logic [DATA_WIDTH-1:0]   wdata;
    } req_t;

    req_t                  w_core_req;
    req_t                  w_bus_req;
    logic                  w_can_issue;
    logic                  w_issue;
    logic [c_CNT_W-1:0]    r_count;
    logic                  r_proto_err;
    logic                  r_resp_valid;
    logic [DATA_WIDTH-1:0] r_resp_rdata;
    logic                  r_resp_err;

    always_comb begin
        w_core_req       = '0;
        w_core_req.addr  = core_addr_i & ~c_OFF_MASK;
        w_core_req.we    = core_we_i;
        w_core_req.be    = core_be_i;
        w_core_req.wdata = core_wdata_i;
    end

    // A response arriving this cycle frees its slot for an issue in the same cycle.
    assign w_can_issue = (r_count < c_MAX) || obi_rvalid_i;
    assign w_issue     = obi_req_o && obi_gnt_i;

    generate
        if (REG_REQ != 0) begin : g_reg_req
            obi_req_slice #(
                .req_t (req_t)
            ) u_req_slice (
                .clk       (clk),
                .rst       (rst),
                .in_valid  (core_valid_i),
                .in_ready  (core_ready_o),
                .in_req    (w_core_req),
                .can_issue (w_can_issue),
                .gnt       (obi_gnt_i),
                .out_req   (obi_req_o),
                .out_data  (w_bus_req)
            );
        end else begin : g_passthru
            assign obi_req_o    = core_valid_i && w_can_issue;
            assign core_ready_o = obi_gnt_i && w_can_issue;
            assign w_bus_req    = w_core_req;
        end
    endgenerate

    assign obi_addr_o  = w_bus_req.addr;
    assign obi_we_o    = w_bus_req.we;
    assign obi_be_o    = w_bus_req.be;
    assign obi_wdata_o = w_bus_req.wdata;
    assign obi_atop_o  = OBI_ATOP_NONE;

    // A response with nothing in flight is flagged and never decrements the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count     <= '0;
            r_proto_err <= 1'b0;
        end else begin
            case ({w_issue, obi_rvalid_i})
                2'b10: r_count <= r_count + c_CNT_W'(1);
                2'b01: begin
                    if (r_count == '0) begin
                        r_proto_err <= 1'b1;
                    end else begin
                        r_count <= r_count - c_CNT_W'(1);
                    end
                end
                2'b11: begin
                    if (r_count == '0) begin
                        r_proto_err <= 1'b1;
                        r_count     <= c_CNT_W'(1);
                    end
                end
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
        end else begin
            r_resp_valid <= obi_rvalid_i;
            r_resp_err   <= obi_rvalid_i && obi_err_i;
            if (obi_rvalid_i) begin
                r_resp_rdata <= obi_rdata_i;
            end
        end
    end

    assign resp_valid_o  = r_resp_valid;
    assign resp_rdata_o  = r_resp_rdata;
    assign resp_err_o    = r_resp_err;
    assign outstanding_o = r_count;
    assign proto_err_o   = r_proto_err;

endmodule

`default_nettype wire

// File: tb/tb_obi_master_pipelined.sv
// ============================================================================
//  Module      : tb_obi_master_pipelined
//  Description : Directed self-checking bench for obi_master_pipelined (REG_REQ=1, 2 outstanding).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_obi_master_pipelined;

    logic        clk;
    logic        rst;
    logic        core_valid_i;
    logic        core_ready_o;
    logic [31:0] core_addr_i;
    logic        core_we_i;
    logic [3:0]  core_be_i;
    logic [31:0] core_wdata_i;
    logic        resp_valid_o;
    logic [31:0] resp_rdata_o;
    logic        resp_err_o;
    logic        obi_req_o;
    logic        obi_gnt_i;
    logic [31:0] obi_addr_o;
    logic        obi_we_o;
    logic [3:0]  obi_be_o;
    logic [31:0] obi_wdata_o;
    logic [5:0]  obi_atop_o;
    logic [31:0] obi_rdata_i;
    logic        obi_rvalid_i;
    logic        obi_err_i;
    logic [1:0]  outstanding_o;
    logic        proto_err_o;

    int n_cmp = 0;
    int n_err = 0;

    obi_master_pipelined #(
        .ADDR_WIDTH      (32),
        .DATA_WIDTH      (32),
        .MAX_OUTSTANDING (2),
        .REG_REQ         (1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .core_valid_i  (core_valid_i),
        .core_ready_o  (core_ready_o),
        .core_addr_i   (core_addr_i),
        .core_we_i     (core_we_i),
        .core_be_i     (core_be_i),
        .core_wdata_i  (core_wdata_i),
        .resp_valid_o  (resp_valid_o),
        .resp_rdata_o  (resp_rdata_o),
        .resp_err_o    (resp_err_o),
        .obi_req_o     (obi_req_o),
        .obi_gnt_i     (obi_gnt_i),
        .obi_addr_o    (obi_addr_o),
        .obi_we_o      (obi_we_o),
        .obi_be_o      (obi_be_o),
        .obi_wdata_o   (obi_wdata_o),
        .obi_atop_o    (obi_atop_o),
        .obi_rdata_i   (obi_rdata_i),
        .obi_rvalid_i  (obi_rvalid_i),
        .obi_err_i     (obi_err_i),
        .outstanding_o (outstanding_o),
        .proto_err_o   (proto_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then sample; the in-flight count must never exceed 2.
    task automatic tick();
        @(posedge clk);
        #1;
        n_cmp++;
        assert (outstanding_o <= 2'd2) else begin
            n_err++;
            $error("FAIL max_outstanding: observed %0d expected <= 2", outstanding_o);
        end
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b1; core_valid_i = 1'b0; core_addr_i = '0; core_we_i = 1'b0;
        core_be_i = '0; core_wdata_i = '0; obi_gnt_i = 1'b0; obi_rdata_i = '0;
        obi_rvalid_i = 1'b0; obi_err_i = 1'b0;
        tick(); tick();
        rst = 1'b0; settle();
        chk("rst_req", obi_req_o, 0);
        chk("rst_cnt", outstanding_o, 0);
        chk("rst_proto", proto_err_o, 0);
        chk("rst_rvalid", resp_valid_o, 0);
        chk("rst_rdata", resp_rdata_o, 0);
        chk("rst_rerr", resp_err_o, 0);
        chk("rst_addr", obi_addr_o, 0);
        chk("rst_ready", core_ready_o, 1);
        chk("atop", obi_atop_o, 0);

        // Single read, immediate grant, response two cycles later
        core_valid_i = 1'b1; core_addr_i = 32'h2000; core_be_i = 4'hF; obi_gnt_i = 1'b1; settle();
        chk("t1_ready_empty", core_ready_o, 1);
        chk("t1_req_before", obi_req_o, 0);
        tick(); core_valid_i = 1'b0; settle();
        chk("t1_req", obi_req_o, 1);
        chk("t1_addr", obi_addr_o, 32'h2000);
        chk("t1_cnt0", outstanding_o, 0);
        tick(); obi_gnt_i = 1'b0; settle();
        chk("t1_cnt1", outstanding_o, 1);
        chk("t1_req_done", obi_req_o, 0);
        tick(); obi_rvalid_i = 1'b1; obi_rdata_i = 32'hDEADBEEF; settle();
        chk("t1_resp_early", resp_valid_o, 0);
        tick(); obi_rvalid_i = 1'b0; obi_rdata_i = '0; settle();
        chk("t1_resp_valid", resp_valid_o, 1);
        chk("t1_resp_rdata", resp_rdata_o, 32'hDEADBEEF);
        chk("t1_resp_err", resp_err_o, 0);
        chk("t1_cnt_back", outstanding_o, 0);
        tick();
        chk("t1_resp_clr", resp_valid_o, 0);
        chk("t1_rdata_hold", resp_rdata_o, 32'hDEADBEEF);

        // Four back-to-back reads against a credit limit of two
        core_valid_i = 1'b1; core_addr_i = 32'h100; obi_gnt_i = 1'b1; settle();
        tick(); core_addr_i = 32'h104; settle();
        chk("t2_req_a0", obi_req_o, 1);
        chk("t2_addr_a0", obi_addr_o, 32'h100);
        chk("t2_ready_a0", core_ready_o, 1);
        tick(); core_addr_i = 32'h108; settle();
        chk("t2_addr_a1", obi_addr_o, 32'h104);
        chk("t2_cnt1", outstanding_o, 1);
        tick(); core_addr_i = 32'h10C; settle();
        chk("t2_cnt2", outstanding_o, 2);
        chk("t2_req_withheld", obi_req_o, 0);
        chk("t2_ready_blocked", core_ready_o, 0);
        chk("t2_addr_a2", obi_addr_o, 32'h108);
        tick();
        chk("t2_still_withheld", obi_req_o, 0);
        chk("t2_still_cnt2", outstanding_o, 2);
        obi_rvalid_i = 1'b1; obi_rdata_i = 32'h11111111; settle();
        chk("t2_req_on_rvalid", obi_req_o, 1);
        chk("t2_ready_on_rvalid", core_ready_o, 1);
        tick(); core_valid_i = 1'b0; obi_rvalid_i = 1'b0; settle();
        chk("t2_cnt_same", outstanding_o, 2);
        chk("t2_resp1", resp_rdata_o, 32'h11111111);
        chk("t2_addr_a3", obi_addr_o, 32'h10C);
        chk("t2_a3_withheld", obi_req_o, 0);
        obi_rvalid_i = 1'b1; obi_rdata_i = 32'h22222222; settle();
        chk("t2_a3_req", obi_req_o, 1);
        tick(); obi_rdata_i = 32'h33333333; settle();
        chk("t2_cnt_a3", outstanding_o, 2);
        chk("t2_idle", obi_req_o, 0);
        chk("t2_resp2", resp_rdata_o, 32'h22222222);
        tick(); obi_rdata_i = 32'h44444444; settle();
        chk("t2_cnt_drain1", outstanding_o, 1);
        tick(); obi_rvalid_i = 1'b0; obi_gnt_i = 1'b0; settle();
        chk("t2_cnt_drain0", outstanding_o, 0);
        chk("t2_resp4", resp_rdata_o, 32'h44444444);

        // Grant stall: registered request must stay stable
        core_valid_i = 1'b1; core_addr_i = 32'h3000; core_we_i = 1'b1;
        core_be_i = 4'b0011; core_wdata_i = 32'hA5A5A5A5; settle();
        tick(); core_valid_i = 1'b0; core_we_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            core_addr_i = 32'h4444 + 32'(i) * 32'h10; core_wdata_i = 32'h12345678 + 32'(i);
            core_be_i = 4'hF; settle();
            chk("t3_req_held", obi_req_o, 1);
            chk("t3_addr_stable", obi_addr_o, 32'h3000);
            chk("t3_be_stable", obi_be_o, 4'b0011);
            chk("t3_wdata_stable", obi_wdata_o, 32'hA5A5A5A5);
            chk("t3_we_stable", obi_we_o, 1);
            chk("t3_ready_low", core_ready_o, 0);
            tick();
        end
        obi_gnt_i = 1'b1; settle();
        chk("t3_ready_on_gnt", core_ready_o, 1);
        tick(); obi_gnt_i = 1'b0; obi_rvalid_i = 1'b1; settle();
        chk("t3_cnt1", outstanding_o, 1);
        tick(); obi_rvalid_i = 1'b0; settle();
        chk("t3_cnt0", outstanding_o, 0);
        chk("t3_wr_resp", resp_valid_o, 1);

        // Unaligned write with an error response
        core_valid_i = 1'b1; core_addr_i = 32'h1003; core_we_i = 1'b1; core_be_i = 4'b1000;
        core_wdata_i = 32'hCAFEF00D; obi_gnt_i = 1'b1; settle();
        tick(); core_valid_i = 1'b0; settle();
        chk("t4_addr_aligned", obi_addr_o, 32'h1000);
        chk("t4_be", obi_be_o, 4'b1000);
        chk("t4_wdata", obi_wdata_o, 32'hCAFEF00D);
        chk("t4_req", obi_req_o, 1);
        tick(); obi_gnt_i = 1'b0; obi_rvalid_i = 1'b1; obi_err_i = 1'b1; settle();
        chk("t4_cnt1", outstanding_o, 1);
        tick(); obi_rvalid_i = 1'b0; obi_err_i = 1'b0; settle();
        chk("t4_resp_err", resp_err_o, 1);
        chk("t4_resp_valid", resp_valid_o, 1);
        chk("t4_cnt0", outstanding_o, 0);

        // Stray response with nothing outstanding
        obi_rvalid_i = 1'b1; settle();
        chk("t5_proto_before", proto_err_o, 0);
        tick(); obi_rvalid_i = 1'b0; settle();
        chk("t5_proto_set", proto_err_o, 1);
        chk("t5_cnt_floor", outstanding_o, 0);
        tick(); tick();
        chk("t5_proto_sticky", proto_err_o, 1);

        // Reset with two transactions in flight
        rst = 1'b1; tick(); rst = 1'b0; settle();
        chk("t6_proto_clr", proto_err_o, 0);
        core_valid_i = 1'b1; core_addr_i = 32'h200; core_we_i = 1'b0; core_be_i = 4'hF;
        obi_gnt_i = 1'b1; settle();
        tick(); core_addr_i = 32'h204; settle();
        tick(); core_valid_i = 1'b0; settle();
        tick();
        chk("t6_cnt2", outstanding_o, 2);
        obi_rdata_i = 32'h55555555; rst = 1'b1; tick(); rst = 1'b0; obi_gnt_i = 1'b0; settle();
        chk("t6_cnt_rst", outstanding_o, 0);
        chk("t6_req_rst", obi_req_o, 0);
        chk("t6_addr_rst", obi_addr_o, 0);
        chk("t6_rvalid_rst", resp_valid_o, 0);
        chk("t6_rdata_rst", resp_rdata_o, 0);
        chk("t6_ready_rst", core_ready_o, 1);
        obi_rvalid_i = 1'b1; tick(); obi_rvalid_i = 1'b0; settle();
        chk("t6_stray_proto", proto_err_o, 1);
        chk("t6_stray_cnt", outstanding_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
